// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Purpose : Single regfile write-port arbiter. ALU results win outright; MDU
//           results queue in a FIFO and drain into free slots.
// Revision: 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_waddr_i,
  input  logic [31:0] alu_wdata_i,
  input  logic        mdu_valid_i,
  output logic        mdu_ready_o,
  input  logic [4:0]  mdu_waddr_i,
  input  logic [31:0] mdu_wdata_i,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        alu_stall_o,
  input  logic [4:0]  qaddr1_i,
  input  logic [4:0]  qaddr2_i,
  output logic        qbusy1_o,
  output logic        qbusy2_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_full    = CW'(DEPTH);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);
  localparam logic [PW-1:0] c_ptr_one = PW'(1);

  logic [4:0]    r_fifo_addr [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_starve_cnt;
  logic          r_we;
  logic [4:0]    r_waddr;
  logic [31:0]   r_wdata;

  logic w_full;
  logic w_empty;
  logic w_alu_eff;
  logic w_accept;
  logic w_push;
  logic w_pop;

  assign w_full    = (r_count == c_full);
  assign w_empty   = (r_count == '0);
  assign w_alu_eff = alu_valid_i && (alu_waddr_i != 5'd0);
  assign w_accept  = mdu_valid_i && !w_full;
  // Writes to x0 complete the handshake but never occupy a slot.
  assign w_push    = w_accept && (mdu_waddr_i != 5'd0);
  assign w_pop     = !w_alu_eff && !w_empty;

  assign mdu_ready_o = !w_full;
  assign alu_stall_o = w_full && (r_starve_cnt == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= mdu_waddr_i;
      r_fifo_data[r_wr_ptr] <= mdu_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve_cnt <= 2'd0;
    end else if (w_pop) begin
      r_starve_cnt <= 2'd0;
    end else if (!w_empty && w_alu_eff && (r_starve_cnt != 2'd3)) begin
      r_starve_cnt <= r_starve_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end else if (w_alu_eff) begin
      r_we    <= 1'b1;
      r_waddr <= alu_waddr_i;
      r_wdata <= alu_wdata_i;
    end else if (w_pop) begin
      r_we    <= 1'b1;
      r_waddr <= r_fifo_addr[r_rd_ptr];
      r_wdata <= r_fifo_data[r_rd_ptr];
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign we_o    = r_we;
  assign waddr_o = r_waddr;
  assign wdata_o = r_wdata;

  // An entry is live when its distance from the read pointer is below count.
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [PW-1:0] c_idx = PW'(gi);
    logic [PW-1:0] w_off;
    logic          w_live;
    assign w_off      = c_idx - r_rd_ptr;
    assign w_live     = ({1'b0, w_off} < r_count);
    assign w_hit1[gi] = w_live && (r_fifo_addr[gi] == qaddr1_i);
    assign w_hit2[gi] = w_live && (r_fifo_addr[gi] == qaddr2_i);
  end

  assign qbusy1_o = (qaddr1_i != 5'd0) && (|w_hit1);
  assign qbusy2_o = (qaddr2_i != 5'd0) && (|w_hit2);

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_arbiter
// Purpose : Directed and random stimulus for wb_arbiter against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk_i;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_waddr_i;
  logic [31:0] alu_wdata_i;
  logic        mdu_valid_i;
  logic        mdu_ready_o;
  logic [4:0]  mdu_waddr_i;
  logic [31:0] mdu_wdata_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        alu_stall_o;
  logic [4:0]  qaddr1_i;
  logic [4:0]  qaddr2_i;
  logic        qbusy1_o;
  logic        qbusy2_o;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_waddr_i (alu_waddr_i),
    .alu_wdata_i (alu_wdata_i),
    .mdu_valid_i (mdu_valid_i),
    .mdu_ready_o (mdu_ready_o),
    .mdu_waddr_i (mdu_waddr_i),
    .mdu_wdata_i (mdu_wdata_i),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .alu_stall_o (alu_stall_o),
    .qaddr1_i    (qaddr1_i),
    .qaddr2_i    (qaddr2_i),
    .qbusy1_o    (qbusy1_o),
    .qbusy2_o    (qbusy2_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queued MDU results in acceptance order, {waddr, wdata}.
  logic [36:0] q[$];
  int          starve  = 0;
  logic        m_we    = 1'b0;
  logic [4:0]  m_waddr = 5'd0;
  logic [31:0] m_wdata = 32'd0;
  logic        m_stall_now = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i][36:32] == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] q1, input logic [4:0] q2);
    logic acc;
    logic [36:0] head;
    alu_valid_i = av; alu_waddr_i = aa; alu_wdata_i = ad;
    mdu_valid_i = mv; mdu_waddr_i = ma; mdu_wdata_i = md;
    qaddr1_i = q1; qaddr2_i = q2;
    #1;
    m_stall_now = (q.size() == DEPTH) && (starve == 3);
    check("mdu_ready", mdu_ready_o, q.size() != DEPTH);
    check("alu_stall", alu_stall_o, m_stall_now);
    check("qbusy1", qbusy1_o, busy(q1));
    check("qbusy2", qbusy2_o, busy(q2));
    acc = mv && (q.size() != DEPTH);
    if (av && aa != 5'd0) begin
      m_we = 1'b1; m_waddr = aa; m_wdata = ad;
      if (q.size() != 0 && starve < 3) starve++;
    end else if (q.size() != 0) begin
      head = q.pop_front();
      m_we = 1'b1; m_waddr = head[36:32]; m_wdata = head[31:0];
      starve = 0;
    end else begin
      m_we = 1'b0;
    end
    if (acc && ma != 5'd0) q.push_back({ma, md});
    @(posedge clk_i);
    #1;
    check("we", we_o, m_we);
    check("waddr", waddr_o, m_waddr);
    check("wdata", wdata_o, m_wdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd3);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_we"}, we_o, 1'b0);
    check({tag, "_waddr"}, waddr_o, 5'd0);
    check({tag, "_wdata"}, wdata_o, 32'd0);
    check({tag, "_ready"}, mdu_ready_o, 1'b1);
    check({tag, "_stall"}, alu_stall_o, 1'b0);
    check({tag, "_qbusy1"}, qbusy1_o, 1'b0);
    check({tag, "_qbusy2"}, qbusy2_o, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1;
    alu_valid_i = 1'b0; alu_waddr_i = 5'd0; alu_wdata_i = 32'd0;
    mdu_valid_i = 1'b0; mdu_waddr_i = 5'd0; mdu_wdata_i = 32'd0;
    qaddr1_i = 5'd7; qaddr2_i = 5'd3;
    #1;
    reset_checks("por");
    @(posedge clk_i);
    #3 rst_i = 1'b0;

    // ALU path, then ALU write to x0 (output address/data hold).
    cycle(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("alu_direct_waddr", waddr_o, 5'd5);
    cycle(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("alu_x0_we", we_o, 1'b0);

    // MDU drain: two pushes, qaddr1 watches register 7.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hA, 5'd7, 5'd3);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB, 5'd7, 5'd3);
    check("drain_first_waddr", waddr_o, 5'd3);
    idle(1);
    check("drain_second_wdata", wdata_o, 32'hB);
    idle(2);

    // Contention: ALU every cycle while offering five MDU results.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 5'(i + 1), 32'h100 + i, 1'b1, 5'(10 + i), 32'h200 + i, 5'd12, 5'd14);
    check("full_ready_low", mdu_ready_o, 1'b0);
    check("full_stall_high", alu_stall_o, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h204, 5'd10, 5'd14);
    check("bubble_pop_head", wdata_o, 32'h200);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h204, 5'd10, 5'd14);
    idle(7);

    // Same-cycle push and pop at count 3.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'd1, 32'h300 + i, 1'b1, 5'(20 + i), 32'h400 + i, 5'd20, 5'd22);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd23, 32'h403, 5'd23, 5'd20);
    check("pushpop_ready", mdu_ready_o, 1'b1);
    idle(5);

    // MDU write to x0 is swallowed.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555, 5'd0, 5'd0);
    check("mdu_x0_we", we_o, 1'b0);
    idle(3);

    // Random traffic honouring the one-bubble rule after a stall.
    for (int n = 0; n < 400; n++) begin
      logic av;
      av = ($urandom_range(0, 3) != 0) && !m_stall_now;
      cycle(av, 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Fill the FIFO, then reset between edges.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 5'd9, 32'h600 + i, 1'b1, 5'(4 + i), 32'h700 + i, 5'd4, 5'd5);
    #2;
    rst_i = 1'b1;
    alu_valid_i = 1'b0; mdu_valid_i = 1'b0;
    #1;
    reset_checks("midrst");
    q.delete(); starve = 0; m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 32'hCAFE, 5'd17, 5'd4);
    check("post_rst_busy", qbusy1_o, 1'b1);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the single regfile write port. It merges results from the in-order ALU/LSU pipeline (no backpressure, fixed priority) with results from the long-latency multiply/divide unit (valid/ready handshake, buffered in a DEPTH-entry FIFO). It drives registered `we_o`/`waddr_o`/`wdata_o` straight into the regfile write port. It also reports per-read-address "pending MDU write" flags that the decode stage uses for interlocks.

## Interface
- `DEPTH`, default 4: MDU result FIFO entries; power of two, at least 2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `alu_valid_i`  in  1  ALU-path result present this cycle; never stalled by this block.
- `alu_waddr_i`  in  5  ALU-path destination register.
- `alu_wdata_i`  in  32  ALU-path result.
- `mdu_valid_i`  in  1  MDU result offered.
- `mdu_ready_o`  out  1  FIFO can accept an MDU result.
- `mdu_waddr_i`  in  5  MDU destination register.
- `mdu_wdata_i`  in  32  MDU result.
- `we_o`  out  1  regfile write enable.
- `waddr_o`  out  5  regfile write address.
- `wdata_o`  out  32  regfile write data.
- `alu_stall_o`  out  1  request one ALU-path bubble so the FIFO can drain.
- `qaddr1_i`, `qaddr2_i`  in  5 each  decode-stage source registers.
- `qbusy1_o`, `qbusy2_o`  out  1 each  a queued MDU write targets the matching `qaddr`.

## Operation
- MDU handshake: a transfer occurs when `mdu_valid_i && mdu_ready_o`.
  - `mdu_ready_o = (count != DEPTH)`. It depends only on registered count, with no same-cycle pass-through when full.
  - A transfer with `mdu_waddr_i == 0` is accepted and discarded. It is not enqueued.
- ALU slot usage: an ALU write is effective when `alu_valid_i && alu_waddr_i != 0`.
- Each cycle, exactly one source may win the write port:
  - An effective ALU write wins. Next edge: `we_o=1`, `waddr_o/wdata_o` take the ALU values.
  - Otherwise, if the FIFO is not empty, the head pops. Next edge: `we_o=1` with the head's address and data.
  - Otherwise, next edge: `we_o=0`, and `waddr_o/wdata_o` hold their previous values.
- Ordering:
  - MDU results are written in acceptance order.
  - A result enqueued in cycle N is eligible to pop no earlier than cycle N+1 (no bypass around the FIFO).
- Push and pop in the same cycle are legal at any count, including count==DEPTH−1→push+pop, where count is unchanged. When full, ready is already 0, so no push is possible.
- Starvation guard:
  - `alu_stall_o = (count == DEPTH) && (starve_cnt == 3)`.
  - `starve_cnt` is a 2-bit saturating counter. It increments each cycle the FIFO is non-empty and the ALU wins. It clears on any pop.
  - Upstream must hold `alu_valid_i=0` in the cycle after `alu_stall_o` is sampled high. The block does not check this.
- Busy query:
  - `qbusyK_o` = 1 iff `qaddrK_i != 0` and any valid FIFO entry has `waddr == qaddrK_i`. This is combinational over the registered FIFO contents.
  - An entry popping this cycle still counts as busy. The entry being pushed this cycle does not count.
- WAW hazards between the ALU and MDU paths to the same register are prevented upstream using qbusy. This block does not reorder to resolve them.

## Timing
- Reset values: `we_o=0`, `waddr_o=0`, `wdata_o=0`, `mdu_ready_o=1`, `alu_stall_o=0`, `qbusy*=0`, count=0, `starve_cnt=0`, FIFO pointers=0.
- Latency:
  - ALU input to regfile write: 1 cycle (registered output). Write data is visible to the regfile read ports 2 edges after input.
  - MDU accept to write: at least 2 cycles (1 cycle enqueue, 1 cycle output register).
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Reset asserted mid-operation:
  - Queued results are lost and outputs return to reset values immediately, without waiting for a clock edge.
  - The first accept is possible on the first edge after release.

## Test plan
- Reset/idle: assert `rst_i` between edges -> all outputs take reset values immediately; `mdu_ready_o=1` after release.
- ALU only: `alu_valid_i=1`, waddr=5, wdata=0x12345678 -> next edge `we_o=1`, `waddr_o=5`, `wdata_o=0x12345678`. Same stimulus with waddr=0 -> `we_o=0`.
- MDU drain:
  - Push {3:0xA}, {7:0xB} with no ALU traffic -> writes appear in order on cycles +2 and +3.
  - `qbusy1_o` is high for `qaddr1_i=7` until the pop cycle of entry 7, inclusive.
- Contention/full, DEPTH=4:
  - Continuous effective ALU writes while pushing 5 MDU results -> 4 are accepted, then `mdu_ready_o=0`.
  - After the full FIFO sees 3 ALU wins, `alu_stall_o=1`.
  - An ALU bubble pops 0x… head, and `mdu_ready_o` returns to 1 on the next cycle.
- Same-cycle push+pop at count=3 -> count stays 3, order is preserved, and no duplicate or lost writes occur.
- MDU result with waddr=0: handshake completes, count is unchanged, and no write is ever issued.
